// File: rtl/omok_win_checker.sv
// Sequential five-in-a-row detector: walks the four lines through the last placed
// stone one cell per clock and reports completed lines of the placing colour.
module omok_win_checker #(
  parameter int unsigned map_size = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   pos,
  input  logic [99:0]  board_state,
  input  logic [99:0]  turn_map,
  output logic         busy,
  output logic         done,
  output logic         win,
  output logic         winner,
  output logic [1:0]   win_dir,
  output logic [3:0]   run_len
);

  localparam int unsigned GRID  = map_size - 1;
  localparam int unsigned CELLS = GRID * GRID;

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

  state_t       state_q, state_d;
  logic [3:0]   row_q, row_d, col_q, col_d, prow_q, prow_d, pcol_q, pcol_d;
  logic [99:0]  occ_q, occ_d, clr_q, clr_d;
  logic         colour_q, colour_d, alive_q, alive_d, found_q, found_d;
  logic [1:0]   dir_q, dir_d, fdir_q, fdir_d;
  logic [2:0]   step_q, step_d, runp_q, runp_d, runm_q, runm_d;
  logic [3:0]   best_q, best_d;
  logic         busy_q, busy_d, done_q, done_d, win_q, win_d, winner_q, winner_d;
  logic [1:0]   win_dir_q, win_dir_d;
  logic [3:0]   run_len_q, run_len_d;

  logic         first, onboard, ok, valid;
  logic [3:0]   base_r, base_c, lrow, lcol, cnt;
  logic [4:0]   dr, dc, nr, nc;
  logic [6:0]   idx, pidx;

  // Probe: next cell along the current direction/side and whether it extends the run.
  always_comb begin
    first  = (step_q[1:0] == 2'd0);
    base_r = first ? row_q : prow_q;
    base_c = first ? col_q : pcol_q;
    dr = 5'd0;
    dc = 5'd0;
    unique case (dir_q)
      2'd0:    dc = 5'd1;
      2'd1:    dr = 5'd1;
      2'd2:    begin dr = 5'd1; dc = 5'd1; end
      default: begin dr = 5'd1; dc = 5'h1f; end
    endcase
    if (step_q[2]) begin
      dr = 5'd0 - dr;
      dc = 5'd0 - dc;
    end
    // Stepping below zero wraps to >= 16, so one upper-bound compare covers both edges.
    nr      = {1'b0, base_r} + dr;
    nc      = {1'b0, base_c} + dc;
    onboard = (nr < 5'(GRID)) && (nc < 5'(GRID));
    idx     = onboard ? (7'(nr) * 7'd10 + 7'(nc)) : 7'd0;
    ok      = (first | alive_q) & onboard & occ_q[idx] & (clr_q[idx] == colour_q);
  end

  // Request decode: row/col by compare chain, validity of the requested cell.
  always_comb begin
    lrow = 4'd0;
    lcol = 4'(pos);
    for (int unsigned r = 1; r < GRID; r++) begin
      if (pos >= 8'(r * 10)) begin
        lrow = 4'(r);
        lcol = 4'(pos - 8'(r * 10));
      end
    end
    pidx  = (pos < 8'(CELLS)) ? 7'(pos) : 7'd0;
    valid = (pos < 8'(CELLS)) && board_state[pidx];
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    prow_d    = prow_q;
    pcol_d    = pcol_q;
    occ_d     = occ_q;
    clr_d     = clr_q;
    colour_d  = colour_q;
    alive_d   = alive_q;
    found_d   = found_q;
    fdir_d    = fdir_q;
    dir_d     = dir_q;
    step_d    = step_q;
    runp_d    = runp_q;
    runm_d    = runm_q;
    best_d    = best_q;
    done_d    = 1'b0;
    win_d     = win_q;
    winner_d  = winner_q;
    win_dir_d = win_dir_q;
    run_len_d = run_len_q;
    cnt       = 4'd0;
    unique case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        row_d    = lrow;
        col_d    = lcol;
        occ_d    = board_state;
        clr_d    = turn_map;
        colour_d = turn_map[pidx];
        dir_d    = 2'd0;
        step_d   = 3'd0;
        best_d   = 4'd1;
        found_d  = 1'b0;
        if (valid) begin
          state_d = SCAN;
        end else begin
          state_d   = DONE;
          done_d    = 1'b1;
          run_len_d = 4'd0;
        end
      end
      SCAN: begin
        prow_d  = nr[3:0];
        pcol_d  = nc[3:0];
        alive_d = ok;
        step_d  = step_q + 3'd1;
        if (!step_q[2]) runp_d = (first ? 3'd0 : runp_q) + {2'b0, ok};
        else            runm_d = (first ? 3'd0 : runm_q) + {2'b0, ok};
        if (step_q == 3'd7) begin
          cnt   = 4'd1 + 4'(runp_q) + 4'(runm_d);
          dir_d = dir_q + 2'd1;
          if (cnt > best_q) best_d = cnt;
          if (cnt >= 4'd5 && !found_q) begin
            found_d = 1'b1;
            fdir_d  = dir_q;
          end
          if (dir_q == 2'd3) begin
            state_d   = DONE;
            done_d    = 1'b1;
            run_len_d = best_d;
            if (!win_q && found_d) begin
              win_d     = 1'b1;
              winner_d  = colour_q;
              win_dir_d = fdir_d;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      prow_q    <= '0;
      pcol_q    <= '0;
      occ_q     <= '0;
      clr_q     <= '0;
      colour_q  <= 1'b0;
      alive_q   <= 1'b0;
      found_q   <= 1'b0;
      fdir_q    <= '0;
      dir_q     <= '0;
      step_q    <= '0;
      runp_q    <= '0;
      runm_q    <= '0;
      best_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      win_q     <= 1'b0;
      winner_q  <= 1'b0;
      win_dir_q <= '0;
      run_len_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      prow_q    <= prow_d;
      pcol_q    <= pcol_d;
      occ_q     <= occ_d;
      clr_q     <= clr_d;
      colour_q  <= colour_d;
      alive_q   <= alive_d;
      found_q   <= found_d;
      fdir_q    <= fdir_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      runp_q    <= runp_d;
      runm_q    <= runm_d;
      best_q    <= best_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      win_q     <= win_d;
      winner_q  <= winner_d;
      win_dir_q <= win_dir_d;
      run_len_q <= run_len_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign win     = win_q;
  assign winner  = winner_q;
  assign win_dir = win_dir_q;
  assign run_len = run_len_q;

endmodule
